// File: rtl/wb_buttons_leds_irq.sv
// rtl/wb_buttons_leds_irq.sv - Wishbone LED/button peripheral with debounce, sticky press events and level irq
module wb_buttons_leds_irq #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0300_0000,
    parameter int          NUM_LEDS        = 8,
    parameter int          NUM_BUTTONS     = 3,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    input  logic                   i_wb_we,
    input  logic [31:0]            i_wb_addr,
    input  logic [31:0]            i_wb_data,
    output logic                   o_wb_ack,
    output logic                   o_wb_stall,
    output logic [31:0]            o_wb_data,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_LEDS-1:0]    leds,
    output logic                   irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] ADDR_LED     = BASE_ADDRESS + 32'h00;
    localparam logic [31:0] ADDR_LED_SET = BASE_ADDRESS + 32'h04;
    localparam logic [31:0] ADDR_LED_CLR = BASE_ADDRESS + 32'h08;
    localparam logic [31:0] ADDR_LED_TOG = BASE_ADDRESS + 32'h0C;
    localparam logic [31:0] ADDR_BTN     = BASE_ADDRESS + 32'h10;
    localparam logic [31:0] ADDR_EVT     = BASE_ADDRESS + 32'h14;
    localparam logic [31:0] ADDR_IRQ_EN  = BASE_ADDRESS + 32'h18;

    logic [NUM_LEDS-1:0]    r_leds;
    logic                   r_ack;
    logic [31:0]            r_rdata;
    logic                   r_irq;
    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [NUM_BUTTONS-1:0] r_deb;
    logic [CNT_W-1:0]       r_cnt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] r_evt;
    logic [NUM_BUTTONS-1:0] r_irq_en;

    logic                   w_access;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_hit_led;
    logic                   w_hit_set;
    logic                   w_hit_clr;
    logic                   w_hit_tog;
    logic                   w_hit_btn;
    logic                   w_hit_evt;
    logic                   w_hit_irq_en;
    logic                   w_mapped;
    logic [NUM_LEDS-1:0]    w_wdata_leds;
    logic [NUM_BUTTONS-1:0] w_wdata_btn;
    logic [NUM_LEDS-1:0]    w_leds_next;
    logic [NUM_BUTTONS-1:0] w_deb_next;
    logic [CNT_W-1:0]       w_cnt_next [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] w_evt_clr;
    logic [NUM_BUTTONS-1:0] w_evt_rise;
    logic [NUM_BUTTONS-1:0] w_evt_next;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    assign w_access     = i_wb_cyc & i_wb_stb;
    assign w_wr         = w_access & i_wb_we;
    assign w_rd         = w_access & ~i_wb_we;

    // Full 32-bit compare: aliases of the window elsewhere in the map stay silent.
    assign w_hit_led    = (i_wb_addr == ADDR_LED);
    assign w_hit_set    = (i_wb_addr == ADDR_LED_SET);
    assign w_hit_clr    = (i_wb_addr == ADDR_LED_CLR);
    assign w_hit_tog    = (i_wb_addr == ADDR_LED_TOG);
    assign w_hit_btn    = (i_wb_addr == ADDR_BTN);
    assign w_hit_evt    = (i_wb_addr == ADDR_EVT);
    assign w_hit_irq_en = (i_wb_addr == ADDR_IRQ_EN);
    assign w_mapped     = w_hit_led | w_hit_set | w_hit_clr | w_hit_tog |
                          w_hit_btn | w_hit_evt | w_hit_irq_en;

    assign w_wdata_leds = i_wb_data[NUM_LEDS-1:0];
    assign w_wdata_btn  = i_wb_data[NUM_BUTTONS-1:0];
    assign w_unused     = ^i_wb_data;

    always_comb begin
        w_leds_next = r_leds;
        if (w_wr) begin
            if (w_hit_led) w_leds_next = w_wdata_leds;
            if (w_hit_set) w_leds_next = r_leds | w_wdata_leds;
            if (w_hit_clr) w_leds_next = r_leds & ~w_wdata_leds;
            if (w_hit_tog) w_leds_next = r_leds ^ w_wdata_leds;
        end
    end

    // Counter runs only while the synchronised pin disagrees with the accepted level.
    always_comb begin
        w_deb_next = r_deb;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_deb[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_deb_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press landing on the same edge as a W1C must not be lost.
    assign w_evt_clr  = (w_wr && w_hit_evt) ? w_wdata_btn : '0;
    assign w_evt_rise = w_deb_next & ~r_deb;
    assign w_evt_next = (r_evt & ~w_evt_clr) | w_evt_rise;

    always_comb begin
        w_rdata = '0;
        if (w_hit_led)    w_rdata[NUM_LEDS-1:0]    = r_leds;
        if (w_hit_btn)    w_rdata[NUM_BUTTONS-1:0] = r_deb;
        if (w_hit_evt)    w_rdata[NUM_BUTTONS-1:0] = r_evt;
        if (w_hit_irq_en) w_rdata[NUM_BUTTONS-1:0] = r_irq_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leds   <= '0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_deb    <= '0;
            r_evt    <= '0;
            r_irq_en <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_next;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_leds <= w_leds_next;
            r_evt  <= w_evt_next;
            if (w_wr && w_hit_irq_en) begin
                r_irq_en <= w_wdata_btn;
            end
            r_irq <= |(r_evt & r_irq_en);
            r_ack <= w_access & w_mapped;
            if (w_rd && w_mapped) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = r_rdata;
    assign leds       = r_leds;
    assign irq        = r_irq;

endmodule
